// File: rtl/bias_bank.sv
`default_nettype none
// ============================================================================
// bias_bank : per-channel signed bias registers with sequential saturating update
// Rev 1.0
// ============================================================================
module bias_bank #(
    parameter int N_CH = 5,
    parameter int W    = 16,
    parameter int AW   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          step,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic [N_CH*W-1:0]   upd_delta,
    input  logic [2:0]          lr_shift,
    input  logic                ld_en,
    input  logic [AW-1:0]       ld_addr,
    input  logic [W-1:0]        ld_data,
    output logic [N_CH*W-1:0]   bias_flat,
    output logic                busy,
    output logic                done,
    output logic                sat_flag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          idx_q, idx_d;
    logic [2:0]             shift_q, shift_d;
    logic                   sat_q, sat_d;
    logic signed [W-1:0]    delta_q [N_CH];
    logic signed [W-1:0]    delta_d [N_CH];
    logic signed [W-1:0]    bias_q  [N_CH];
    logic signed [W-1:0]    bias_d  [N_CH];

    logic                   accept;
    logic signed [W-1:0]    cur_bias;
    logic signed [W-1:0]    cur_delta;
    logic signed [W-1:0]    shifted;
    logic signed [W:0]      sum;
    logic                   clamp;
    logic signed [W-1:0]    clamped;

    assign upd_ready = (state_q == IDLE) && !ld_en;
    assign accept    = upd_valid && upd_ready;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign sat_flag  = sat_q;

    // Channel currently being updated, shifted delta and saturating sum
    always_comb begin
        cur_bias  = '0;
        cur_delta = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (idx_q == AW'(k)) begin
                cur_bias  = bias_q[k];
                cur_delta = delta_q[k];
            end
        end
        shifted = cur_delta >>> shift_q;
        sum     = {cur_bias[W-1], cur_bias} + {shifted[W-1], shifted};
        // Overflow iff the two top bits of the W+1 bit sum disagree
        clamp   = sum[W] ^ sum[W-1];
        if (clamp) begin
            clamped = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            clamped = sum[W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        sat_d   = sat_q;
        delta_d = delta_q;
        bias_d  = bias_q;
        case (state_q)
            IDLE: begin
                if (ld_en) begin
                    // Out-of-range addresses match no channel and are dropped
                    for (int k = 0; k < N_CH; k++) begin
                        if (ld_addr == AW'(k)) begin
                            bias_d[k] = ld_data;
                        end
                    end
                end else if (accept) begin
                    for (int k = 0; k < N_CH; k++) begin
                        delta_d[k] = upd_delta[k*W +: W];
                    end
                    shift_d = lr_shift;
                    sat_d   = 1'b0;
                    idx_d   = '0;
                    state_d = (step != 4'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                for (int k = 0; k < N_CH; k++) begin
                    if (idx_q == AW'(k)) begin
                        bias_d[k] = clamped;
                    end
                end
                if (clamp) begin
                    sat_d = 1'b1;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == AW'(N_CH-1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            sat_q   <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                delta_q[k] <= '0;
                bias_q[k]  <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            sat_q   <= sat_d;
            for (int k = 0; k < N_CH; k++) begin
                delta_q[k] <= delta_d[k];
                bias_q[k]  <= bias_d[k];
            end
        end
    end

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_flat
            assign bias_flat[g*W +: W] = bias_q[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bias_bank.sv
`default_nettype none
// ============================================================================
// tb_bias_bank : table-driven updates with a scoreboard queue, plus corner sequences
// Rev 1.0
// ============================================================================
module tb_bias_bank;

    localparam int N_CH = 5;
    localparam int W    = 16;
    localparam int AW   = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [3:0]          step = '0;
    logic                upd_valid = 1'b0;
    logic                upd_ready;
    logic [N_CH*W-1:0]   upd_delta = '0;
    logic [2:0]          lr_shift = '0;
    logic                ld_en = 1'b0;
    logic [AW-1:0]       ld_addr = '0;
    logic [W-1:0]        ld_data = '0;
    logic [N_CH*W-1:0]   bias_flat;
    logic                busy;
    logic                done;
    logic                sat_flag;

    bias_bank #(.N_CH(N_CH), .W(W), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .step(step), .upd_valid(upd_valid),
        .upd_ready(upd_ready), .upd_delta(upd_delta), .lr_shift(lr_shift),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .bias_flat(bias_flat), .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [W-1:0] init  [N_CH];
        logic [3:0]          stp;
        logic [2:0]          shf;
        logic signed [W-1:0] delta [N_CH];
        logic signed [W-1:0] expb  [N_CH];
        logic                exps;
        int                  lat;
    } vec_t;

    vec_t tbl [6];
    vec_t sb [$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [31:0] ch(input int k);
        logic signed [W-1:0] v;
        v = bias_flat[k*W +: W];
        return 32'(v);
    endfunction

    task automatic load(input int addr, input logic signed [W-1:0] data);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = AW'(addr);
        ld_data = data;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int   lat;
        vec_t e;
        for (int k = 0; k < N_CH; k++) load(k, v.init[k]);
        @(negedge clk);
        upd_valid = 1'b1;
        step      = v.stp;
        lr_shift  = v.shf;
        for (int k = 0; k < N_CH; k++) upd_delta[k*W +: W] = v.delta[k];
        @(posedge clk);
        sb.push_back(v);
        #1;
        upd_valid = 1'b0;
        lat = 1;
        // Scramble every input while the update runs; none of it may matter
        while (done !== 1'b1 && lat < 20) begin
            for (int k = 0; k < N_CH; k++) upd_delta[k*W +: W] = W'($urandom);
            lr_shift = 3'($urandom);
            step     = 4'($urandom);
            ld_en    = 1'b1;
            ld_addr  = AW'($urandom_range(0, N_CH-1));
            ld_data  = W'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        ld_en = 1'b0;
        if (done !== 1'b1) begin
            chk($sformatf("v%0d_timeout", id), 0, 1);
            sb.delete();
        end else begin
            e = sb.pop_front();
            for (int k = 0; k < N_CH; k++)
                chk($sformatf("v%0d_ch%0d", id, k), ch(k), 32'(e.expb[k]));
            chk($sformatf("v%0d_sat", id), 32'(sat_flag), 32'(e.exps));
            chk($sformatf("v%0d_latency", id), lat, e.lat);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_busy_after", id), 32'(busy), 0);
        end
    endtask

    initial begin
        int seen;
        tbl[0] = '{'{10, 20, 30, 40, 50}, 4'd1, 3'd0, '{1, -2, 3, -4, 5},
                   '{11, 18, 33, 36, 55}, 1'b0, 6};
        tbl[1] = '{'{0, 0, 32760, -32760, 0}, 4'd1, 3'd0, '{0, 0, 100, -100, 0},
                   '{0, 0, 32767, -32768, 0}, 1'b1, 6};
        tbl[2] = '{'{0, 0, 0, 0, 0}, 4'd1, 3'd2, '{-7, 8, 0, 0, 0},
                   '{-2, 2, 0, 0, 0}, 1'b0, 6};
        tbl[3] = '{'{100, -100, 0, 32767, -32768}, 4'd3, 3'd7,
                   '{32767, -32768, -1, 1, -1},
                   '{355, -356, -1, 32767, -32768}, 1'b1, 6};
        tbl[4] = '{'{1, 2, 3, 4, 5}, 4'd0, 3'd0, '{9, 9, 9, 9, 9},
                   '{1, 2, 3, 4, 5}, 1'b0, 1};
        tbl[5] = '{'{-32768, 0, 0, 0, 0}, 4'd15, 3'd1, '{-32768, 3, -3, 1, -1},
                   '{-32768, 1, -2, 0, -1}, 1'b1, 6};

        // Reset state
        #12;
        for (int k = 0; k < N_CH; k++) chk($sformatf("rst_ch%0d", k), ch(k), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sat", 32'(sat_flag), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(upd_ready), 1);

        for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

        // Load concurrent with update request: load wins, no accept
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'd77;
        upd_valid = 1'b1; step = 4'd1; lr_shift = 3'd0;
        for (int k = 0; k < N_CH; k++) upd_delta[k*W +: W] = 16'd1;
        @(posedge clk); #1;
        ld_en = 1'b0; upd_valid = 1'b0;
        chk("ldwin_ch1", ch(1), 77);
        chk("ldwin_ch0", ch(0), -32768);
        chk("ldwin_busy", 32'(busy), 0);

        // Out-of-range load address
        load(7, 16'd999);
        #1;
        chk("oob_ch0", ch(0), -32768);
        chk("oob_ch1", ch(1), 77);
        chk("oob_ch4", ch(4), -1);

        // Held upd_valid with step 0: done, gap, done
        @(negedge clk);
        upd_valid = 1'b1; step = 4'd0;
        @(posedge clk); #1;
        chk("hold_done0", 32'(done), 1);
        @(posedge clk); #1;
        chk("hold_done1", 32'(done), 0);
        chk("hold_ready1", 32'(upd_ready), 1);
        @(posedge clk); #1;
        chk("hold_done2", 32'(done), 1);
        upd_valid = 1'b0;
        @(posedge clk); #1;

        // Reset asserted mid-update after ch0, ch1 are written
        for (int k = 0; k < N_CH; k++) load(k, W'(k + 1));
        @(negedge clk);
        upd_valid = 1'b1; step = 4'd1; lr_shift = 3'd0;
        for (int k = 0; k < N_CH; k++) upd_delta[k*W +: W] = 16'd10;
        @(posedge clk); #1;
        upd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("mid_ch1_written", ch(1), 12);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < N_CH; k++) chk($sformatf("mid_rst_ch%0d", k), ch(k), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        seen = 0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(upd_ready), 1);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        chk("mid_no_done", seen, 0);
        chk("mid_ch0_held", ch(0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/bias_bank.md
BIAS_BANK -- requirements
Module: bias_bank

Interface
REQ-001 Parameter N_CH, default 5: number of bias channels, 1..16.
REQ-002 Parameter W, default 16: signed two's-complement bias/delta width, 8..32.
REQ-003 Parameter AW, default 3: load address width, at least clog2(N_CH).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 step  in  4  training step index; 0 inhibits bias modification.
REQ-007 upd_valid  in  1  update request.
REQ-008 upd_ready  out  1  block can accept update request.
REQ-009 upd_delta  in  N_CH*W  flat delta bus; channel k at bits [k*W +: W], signed.
REQ-010 lr_shift  in  3  arithmetic right-shift applied to each delta (learning-rate scale).
REQ-011 ld_en  in  1  direct bias write strobe.
REQ-012 ld_addr  in  AW  channel index for direct write.
REQ-013 ld_data  in  W  signed value for direct write.
REQ-014 bias_flat  out  N_CH*W  current biases, channel k at [k*W +: W], driven straight from registers.
REQ-015 busy  out  1  high in RUN and DONE.
REQ-016 done  out  1  one-cycle pulse at end of an accepted update.
REQ-017 sat_flag  out  1  sticky: any channel clamped during the current or last update.

Function
REQ-018 FSM states IDLE, RUN, DONE; upd_ready = (state==IDLE) && !ld_en.
REQ-019 Accept = upd_valid && upd_ready; on accept capture upd_delta, lr_shift and step, clear sat_flag, clear idx to 0.
REQ-020 IDLE -> RUN on accept with captured step != 0; IDLE -> DONE on accept with captured step == 0 (no bias change).
REQ-021 RUN: each cycle bias[idx] <= sat(bias[idx] + (delta[idx] >>> lr_shift)), idx++; one channel per cycle.
REQ-022 RUN -> DONE in the same cycle channel N_CH-1 is written; DONE -> IDLE unconditionally after one cycle.
REQ-023 done high exactly while in DONE; update latency = N_CH+1 cycles from accept edge to done (step!=0), 1 cycle (step==0).
REQ-024 Arithmetic: shift sign-extends; sum formed at W+1 bits; result clamped to [-2^(W-1), 2^(W-1)-1]; clamp sets sat_flag.
REQ-025 Inputs upd_delta, lr_shift and step are ignored after accept; changes during RUN have no effect.
REQ-026 ld_en in IDLE with ld_addr < N_CH writes bias[ld_addr] <= ld_data next edge; ld_addr >= N_CH ignored.
REQ-027 ld_en while busy ignored entirely; ld_en concurrent with upd_valid in IDLE: load wins, update not accepted.
REQ-028 bias_flat reflects each channel write on the cycle after its edge; untouched channels hold value.
REQ-029 upd_valid held high through DONE is accepted again only after return to IDLE (back-to-back gap of one IDLE cycle).

Reset
REQ-030 rst_n low asynchronously forces state IDLE, idx 0, all biases 0, done 0, busy 0, sat_flag 0; upd_ready 1 after release (if ld_en low).
REQ-031 Reset asserted mid-RUN abandons the update; channels already written are also cleared to 0.
REQ-032 First edge after rst_n rises behaves as IDLE.

Verification
REQ-033 Load ch0..4 = 10,20,30,40,50; update step=1, lr_shift=0, deltas 1,-2,3,-4,5 -> biases 11,18,33,36,55, done at accept+6, sat_flag 0.
REQ-034 Bias ch2=32760, delta ch2=100, lr_shift=0 -> ch2=32767, sat_flag 1; ch3=-32760 with delta -100 -> -32768.
REQ-035 lr_shift=2, delta -7 on ch0 with bias 0 -> ch0=-2 (arithmetic shift floor); delta 8 -> +2.
REQ-036 Accept with step=0, nonzero deltas -> biases unchanged, done pulses at accept+1, busy high 1 cycle.
REQ-037 Pull rst_n low two cycles after accept (ch0,ch1 written) -> all bias_flat 0 immediately, done never pulses, upd_ready 1 after release.
REQ-038 ld_en and upd_valid both high in IDLE -> load applied, no accept; ld_en during RUN and ld_addr=7 in IDLE -> no bias change.
